if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and the decode stage. Each cycle it accepts one `{pc, instruction}` pair from fetch and presents the oldest buffered pair to decode. It decouples fetch from decode stalls. When it fills, it back-pressures fetch through `full`, which drives the fetch freeze. A taken branch from later in the pipeline flushes every queued wrong-path instruction.

## Interface
- `DEPTH`, default 4, number of entries; power of two, at least 2.
- `WIDTH`, default 32, width of the PC field and of the instruction field.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch presents a valid pair this cycle.
- `in_pc`  in  WIDTH  fetch PC output (already PC+4); carried unchanged.
- `in_instruction`  in  WIDTH  fetched instruction word.
- `full`  out  1  queue holds DEPTH entries; wired to the fetch freeze input.
- `flush`  in  1  branch taken; discard all queued entries.
- `out_ready`  in  1  decode accepts the head entry this cycle (low when decode stalls on a hazard).
- `out_valid`  out  1  head entry valid; when low, decode inserts a bubble.
- `out_pc`  out  WIDTH  PC of the head entry.
- `out_instruction`  out  WIDTH  instruction of the head entry.
- `count`  out  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH `{pc, instruction}` entries, with write pointer `wp`, read pointer `rp` and occupancy `count`.
- Push condition: `push = in_valid & ~full & ~flush`.
  - Writes `mem[wp]` and advances `wp` modulo DEPTH.
- Pop condition: `pop = out_valid & out_ready & ~flush`.
  - Advances `rp` modulo DEPTH.
- Count update: `count` +1 on push only, -1 on pop only, unchanged when both or neither occur.
- `full = (count == DEPTH)`, `out_valid = (count != 0)`. Both are decoded from registered `count` only, with no combinational path from `in_valid`, `out_ready` or `flush`.
- Full queue: a push is refused even if a pop occurs in the same cycle. Fetch is already frozen by `full`, so the refused pair is re-presented next cycle.
- Empty queue: `out_pc` and `out_instruction` are forced to 0 and `out_valid` is 0. A push into an empty queue becomes visible at the head on the following cycle (no bypass).
- Flush has priority over push and pop. On flush:
  - `wp`, `rp` and `count` clear to 0.
  - The incoming pair that cycle is discarded.
  - Next cycle `out_valid` is 0 and `full` is 0.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no other effect. Order is strictly FIFO.
- Illegal or guarded cases: push while full and pop while empty are impossible by construction. `count` never exceeds DEPTH and never goes below 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `wp`, `rp` and `count` are 0.
  - `full` = 0, `out_valid` = 0.
  - `out_pc` = 0, `out_instruction` = 0.
  - Storage contents are don't-care; the outputs mask them.
- Deassertion of `rst` is sampled synchronously; the first push can occur on the first rising edge after deassertion.
- Latency: 1 cycle from an accepted push to the entry being at the head of an empty queue.
- Throughput: 1 entry per cycle in steady state with `out_ready` = 1. `count` then stays at 1 and `full` is never asserted.
- Reset in the middle of operation: all entries are lost. Behaviour is identical to a flush, but asynchronous.
- Flush and reset may arrive in any cycle with no precondition.

## Test plan
- Reset, then `in_valid` = 1 for 3 cycles with PCs 4, 8, 12 and `out_ready` = 0: `count` goes 1, 2, 3; `out_pc` = 4 from cycle 2 onward; `full` = 0.
- Continue pushing with `out_ready` = 0: after the 4th push `count` = 4 and `full` = 1. A 5th pair (PC 20) held on the inputs is not accepted. Set `out_ready` = 1: outputs pop as 4, 8, 12, 16, then 20 after `full` drops.
- Steady stream with `in_valid` = 1 and `out_ready` = 1 over more than 2×DEPTH pushes: outputs appear in order PC 4, 8, 12, ... one cycle after each push; `count` stays at 1; pointers wrap twice with no loss or duplication.
- Queue holding 3 entries; assert `flush` with `in_valid` = 1 (PC 40) and `out_ready` = 1 in the same cycle: next cycle `count` = 0 and `out_valid` = 0. PC 40 is never output, and the next pushed PC (0x100) is the next output.
- Assert `rst` asynchronously in the middle of a cycle with `count` = 2: immediately `count` = 0, `out_valid` = 0 and `out_instruction` = 0, without waiting for a clock edge.
- Empty queue with `out_ready` = 1 and `in_valid` = 0 for 5 cycles: `out_valid` stays 0 and `out_pc` stays 0.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: instruction queue between fetch and decode.
//
// Buffers {pc, instruction} pairs in a DEPTH-entry circular buffer. The head
// pair goes to decode. Fetch is held off through `full`. A taken branch
// (`flush`) drops every queued entry.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid          fetch presents a pair this cycle
//   in_pc             fetch PC (already PC+4), carried unchanged
//   in_instruction    fetched instruction word
//   full              queue holds DEPTH entries (drives fetch freeze)
//   flush             branch taken: discard all entries and the incoming pair
//   out_ready         decode accepts the head entry this cycle
//   out_valid         head entry is valid
//   out_pc            head PC (0 when empty)
//   out_instruction   head instruction (0 when empty)
//   count             occupied entries, 0..DEPTH
module if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instruction,
    output logic                       full,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instruction,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_pc_q [DEPTH];
    logic [WIDTH-1:0] mem_pc_d [DEPTH];
    logic [WIDTH-1:0] mem_instr_q [DEPTH];
    logic [WIDTH-1:0] mem_instr_d [DEPTH];

    logic push;
    logic pop;

    // Status comes from the registered count only, so full/out_valid have no
    // combinational path from the handshake or flush inputs.
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // A full queue refuses the push even if a pop frees a slot this cycle.
    assign push = in_valid & ~full & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Storage is never trusted when empty; the outputs mask it to zero.
    assign out_pc          = out_valid ? mem_pc_q[rp_q]    : '0;
    assign out_instruction = out_valid ? mem_instr_q[rp_q] : '0;

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;

        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_pc_d[wp_q]    = in_pc;
                mem_instr_d[wp_q] = in_instruction;
                // DEPTH is a power of two, so natural overflow is the wrap.
                wp_d              = wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = rp_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; contents are masked while empty.
    always_ff @(posedge clk) begin
        mem_pc_q    <= mem_pc_d;
        mem_instr_q <= mem_instr_d;
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        full;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    int total;
    int bad;

    if_id_queue #(
        .DEPTH(4),
        .WIDTH(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_instruction (in_instruction),
        .full           (full),
        .flush          (flush),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instruction(out_instruction),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction word tied to its PC so order errors show up in both fields.
    function automatic logic [31:0] ins(input logic [31:0] pc);
        return (pc * 32'd3) + 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins(pc);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] c, input logic [31:0] pc);
        chk({tag, "_count"}, 32'(count), c);
        chk({tag, "_valid"}, 32'(out_valid), 32'(c != 0));
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_ins"}, out_instruction, (c != 0) ? ins(pc) : 32'h0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0);

        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_ins", out_instruction, 32'd0);
        #11;
        rst = 1'b0;

        // Fill with decode stalled.
        drive(1'b1, 32'd4);
        step(); chk_head("fill1", 1, 32'd4); chk("fill1_full", 32'(full), 32'd0);
        drive(1'b1, 32'd8);
        step(); chk_head("fill2", 2, 32'd4); chk("fill2_full", 32'(full), 32'd0);
        drive(1'b1, 32'd12);
        step(); chk_head("fill3", 3, 32'd4); chk("fill3_full", 32'(full), 32'd0);
        drive(1'b1, 32'd16);
        step(); chk_head("fill4", 4, 32'd4); chk("fill4_full", 32'(full), 32'd1);
        drive(1'b1, 32'd20);
        step(); chk_head("held20", 4, 32'd4); chk("held20_full", 32'(full), 32'd1);

        // Drain: the pop while full does not admit PC 20.
        out_ready = 1'b1;
        step(); chk_head("drain1", 3, 32'd8); chk("drain1_full", 32'(full), 32'd0);
        step(); chk_head("drain2", 3, 32'd12);
        drive(1'b0, 32'd0);
        step(); chk_head("drain3", 2, 32'd16);
        step(); chk_head("drain4", 1, 32'd20);
        step(); chk_head("drain5", 0, 32'd0);

        // Steady stream: count holds at 1, pointers wrap twice.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'd4 + 32'd4 * 32'(i));
            step();
            chk_head($sformatf("stream%0d", i), 1, 32'd4 + 32'd4 * 32'(i));
            chk($sformatf("stream%0d_full", i), 32'(full), 32'd0);
        end
        drive(1'b0, 32'd0);
        step(); chk_head("stream_end", 0, 32'd0);

        // Flush with three queued and a pair on the input.
        out_ready = 1'b0;
        drive(1'b1, 32'd28); step();
        drive(1'b1, 32'd32); step();
        drive(1'b1, 32'd36); step();
        chk_head("preflush", 3, 32'd28);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'd40);
        step(); chk_head("flush", 0, 32'd0); chk("flush_full", 32'(full), 32'd0);
        flush = 1'b0;
        drive(1'b1, 32'h100);
        step(); chk_head("postflush", 1, 32'h100);
        drive(1'b0, 32'd0);
        step(); chk_head("postflush_empty", 0, 32'd0);

        // Asynchronous reset mid-cycle with two entries queued.
        out_ready = 1'b0;
        drive(1'b1, 32'h200); step();
        drive(1'b1, 32'h204); step();
        drive(1'b0, 32'd0);
        chk_head("prerst", 2, 32'h200);
        #3;
        rst = 1'b1;
        #1;
        chk_head("async_rst", 0, 32'd0);
        chk("async_rst_full", 32'(full), 32'd0);
        #2;
        rst = 1'b0;

        // Idle with decode ready.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle%0d_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("idle%0d_pc", i), out_pc, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
